// File: rtl/perceptron_proto_pkg.sv
// rtl/perceptron_proto_pkg.sv - perceptron byte-protocol constants shared by host and slave
package perceptron_proto_pkg;

  typedef enum logic [7:0] {
    OP_READ          = 8'd5,
    OP_WRITE_WEIGHTS = 8'd50,
    OP_WRITE_INPUTS  = 8'd51
  } op_byte_e;

  typedef enum logic [7:0] {
    RESP_OK  = 8'd101,
    RESP_ERR = 8'd102
  } resp_byte_e;

  typedef enum logic [1:0] {
    CMD_WRITE_WEIGHTS = 2'd0,
    CMD_WRITE_INPUTS  = 2'd1,
    CMD_READ          = 2'd2,
    CMD_RESERVED      = 2'd3
  } cmd_op_e;

  localparam logic [2:0] WR_PAYLOAD_BYTES = 3'd4;
  localparam logic [2:0] WR_REPLY_BYTES   = 3'd1;
  localparam logic [2:0] RD_REPLY_BYTES   = 3'd6;

  function automatic logic [7:0] cmd_opcode(input cmd_op_e op);
    case (op)
      CMD_WRITE_WEIGHTS: cmd_opcode = OP_WRITE_WEIGHTS;
      CMD_WRITE_INPUTS:  cmd_opcode = OP_WRITE_INPUTS;
      CMD_READ:          cmd_opcode = OP_READ;
      default:           cmd_opcode = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/phm_tx_sequencer.sv
// rtl/phm_tx_sequencer.sv - sends opcode plus optional payload bytes through the UART TX handshake
module phm_tx_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [7:0]  opcode_i,
  input  logic [31:0] payload_i,
  input  logic [2:0]  payload_len_i,
  input  logic        tx_busy_i,
  output logic [7:0]  tx_byte_o,
  output logic        tx_send_o,
  output logic        sending_op_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    T_IDLE,
    T_SEND_OP,
    T_GAP,
    T_WAIT,
    T_SEND_DATA
  } tx_state_e;

  tx_state_e   state_q, state_d;
  logic [7:0]  byte_q, byte_d;
  logic [31:0] payload_q, payload_d;
  logic [2:0]  left_q, left_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= T_IDLE;
      byte_q    <= 8'd0;
      payload_q <= 32'd0;
      left_q    <= 3'd0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      payload_q <= payload_d;
      left_q    <= left_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    payload_d = payload_q;
    left_d    = left_q;
    tx_send_o = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      T_IDLE: begin
        if (start_i) begin
          byte_d    = opcode_i;
          payload_d = payload_i;
          left_d    = payload_len_i;
          state_d   = T_SEND_OP;
        end
      end
      T_SEND_OP, T_SEND_DATA: begin
        if (!tx_busy_i) begin
          tx_send_o = 1'b1;
          state_d   = T_GAP;
        end
      end
      T_GAP: state_d = T_WAIT;
      T_WAIT: begin
        if (!tx_busy_i) begin
          if (left_q == 3'd0) begin
            done_o  = 1'b1;
            state_d = T_IDLE;
          end else begin
            // Payload goes out MSB first; byte_q stays put until the UART is done with it.
            byte_d    = payload_q[31:24];
            payload_d = {payload_q[23:0], 8'h00};
            left_d    = left_q - 3'd1;
            state_d   = T_SEND_DATA;
          end
        end
      end
      default: state_d = T_IDLE;
    endcase
  end

  assign tx_byte_o    = byte_q;
  assign sending_op_o = (state_q == T_SEND_OP);

endmodule

// File: rtl/perceptron_host_master.sv
// rtl/perceptron_host_master.sv - host-side perceptron protocol initiator over a UART byte pair
// Optional per-byte reply timeout is built when PHM_TIMEOUT_EN is defined.
module perceptron_host_master
  import perceptron_proto_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [31:0] cmd_data_i,
  output logic [7:0]  tx_byte_o,
  output logic        tx_send_o,
  input  logic        tx_busy_i,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_ready_i,
  output logic        rx_clear_o,
  output logic        rsp_valid_o,
  output logic        rsp_err_o,
  output logic [7:0]  rsp_code_o,
  output logic [15:0] rd_weight1_o,
  output logic [15:0] rd_weight2_o,
  output logic [15:0] rd_result_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_RX_FLUSH,
    S_RX_WAIT,
    S_RX_TAKE,
    S_RSP
  } state_e;

  state_e      state_q, state_d;
  logic        is_read_q, is_read_d;
  logic [2:0]  rx_cnt_q, rx_cnt_d;
  logic [39:0] shadow_q, shadow_d;
  logic [47:0] rd_q, rd_d;
  logic        err_q, err_d;
  logic [7:0]  code_q, code_d;
  logic        seq_start, seq_send_op, seq_done, timeout;
  logic [7:0]  seq_opcode;
  logic [2:0]  seq_len;
  cmd_op_e     cmd_op;

  assign cmd_op     = cmd_op_e'(cmd_op_i);
  assign seq_opcode = cmd_opcode(cmd_op);
  assign seq_len    = (cmd_op == CMD_READ) ? 3'd0 : WR_PAYLOAD_BYTES;

  phm_tx_sequencer u_tx_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (seq_start),
    .opcode_i     (seq_opcode),
    .payload_i    (cmd_data_i),
    .payload_len_i(seq_len),
    .tx_busy_i    (tx_busy_i),
    .tx_byte_o    (tx_byte_o),
    .tx_send_o    (tx_send_o),
    .sending_op_o (seq_send_op),
    .done_o       (seq_done)
  );

`ifdef PHM_TIMEOUT_EN
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);
  logic [23:0] timer_q;

  // Any state other than RX_WAIT holds the timer at zero, so it restarts per reply byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= 24'd0;
    end else if (state_q != S_RX_WAIT) begin
      timer_q <= 24'd0;
    end else begin
      timer_q <= timer_q + 24'd1;
    end
  end

  assign timeout = (state_q == S_RX_WAIT) && (timer_q == TIMEOUT_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      is_read_q <= 1'b0;
      rx_cnt_q  <= 3'd0;
      shadow_q  <= 40'd0;
      rd_q      <= 48'd0;
      err_q     <= 1'b0;
      code_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      is_read_q <= is_read_d;
      rx_cnt_q  <= rx_cnt_d;
      shadow_q  <= shadow_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_read_d  = is_read_q;
    rx_cnt_d   = rx_cnt_q;
    shadow_d   = shadow_q;
    rd_d       = rd_q;
    err_d      = err_q;
    code_d     = code_q;
    seq_start  = 1'b0;
    rx_clear_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Late duplicates from the slave are dropped here without touching rsp_code.
        rx_clear_o = rx_ready_i;
        if (cmd_valid_i) begin
          if (cmd_op == CMD_RESERVED) begin
            err_d   = 1'b1;
            code_d  = 8'd0;
            state_d = S_RSP;
          end else begin
            seq_start = 1'b1;
            is_read_d = (cmd_op == CMD_READ);
            rx_cnt_d  = (cmd_op == CMD_READ) ? RD_REPLY_BYTES : WR_REPLY_BYTES;
            shadow_d  = 40'd0;
            state_d   = S_TX;
          end
        end
      end
      S_TX: begin
        rx_clear_o = rx_ready_i & seq_send_op;
        if (seq_done) state_d = S_RX_FLUSH;
      end
      S_RX_FLUSH: state_d = S_RX_WAIT;
      S_RX_WAIT: begin
        if (rx_ready_i) begin
          state_d = S_RX_TAKE;
        end else if (timeout) begin
          err_d   = 1'b1;
          code_d  = 8'd0;
          state_d = S_RSP;
        end
      end
      S_RX_TAKE: begin
        rx_clear_o = 1'b1;
        shadow_d   = {shadow_q[31:0], rx_byte_i};
        rx_cnt_d   = rx_cnt_q - 3'd1;
        if (rx_cnt_q == 3'd1) begin
          code_d  = rx_byte_i;
          state_d = S_RSP;
          if (is_read_q) begin
            err_d = 1'b0;
            rd_d  = {shadow_q, rx_byte_i};
          end else begin
            err_d = (rx_byte_i != RESP_OK);
          end
        end else begin
          state_d = S_RX_WAIT;
        end
      end
      S_RSP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign busy_o       = ~cmd_ready_o;
  assign rsp_valid_o  = (state_q == S_RSP);
  assign rsp_err_o    = err_q;
  assign rsp_code_o   = code_q;
  assign rd_weight1_o = rd_q[47:32];
  assign rd_weight2_o = rd_q[31:16];
  assign rd_result_o  = rd_q[15:0];

endmodule

// File: tb/tb_perceptron_host_master.sv
// tb/tb_perceptron_host_master.sv - directed self-checking bench for perceptron_host_master
module tb_perceptron_host_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_data = 32'd0;
  logic [7:0]  tx_byte;
  logic        tx_send;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_byte = 8'd0;
  logic        rx_ready = 1'b0;
  logic        rx_clear;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_code;
  logic [15:0] rd_weight1, rd_weight2, rd_result;
  logic        busy;

  always #5 clk = ~clk;

  perceptron_host_master #(.TIMEOUT_CYCLES(100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_data_i  (cmd_data),
    .tx_byte_o   (tx_byte),
    .tx_send_o   (tx_send),
    .tx_busy_i   (tx_busy),
    .rx_byte_i   (rx_byte),
    .rx_ready_i  (rx_ready),
    .rx_clear_o  (rx_clear),
    .rsp_valid_o (rsp_valid),
    .rsp_err_o   (rsp_err),
    .rsp_code_o  (rsp_code),
    .rd_weight1_o(rd_weight1),
    .rd_weight2_o(rd_weight2),
    .rd_result_o (rd_result),
    .busy_o      (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // UART TX model: busy for busy_len cycles after each accepted send.
  logic [7:0] tx_log[$];
  int busy_len = 3;
  int busy_left = 0;
  int n_viol = 0;
  int first_send_edge = 0;
  logic snd;
  always begin
    @(negedge clk);
    snd = tx_send;
    if (tx_send && tx_busy) n_viol++;
    if (tx_send) begin
      tx_log.push_back(tx_byte);
      if (tx_log.size() == 1) first_send_edge = cyc + 1;
    end
    @(posedge clk);
    #1;
    if (snd) begin
      tx_busy   = 1'b1;
      busy_left = busy_len;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) tx_busy = 1'b0;
    end
  end

  // UART RX model: presents queued bytes one at a time, level until cleared.
  logic [7:0] rx_q[$];
  int clr_cnt = 0;
  int last_clr_edge = 0;
  logic clr;
  always begin
    @(negedge clk);
    clr = rx_clear && rx_ready;
    if (clr) begin
      clr_cnt++;
      last_clr_edge = cyc + 1;
    end
    @(posedge clk);
    #1;
    if (clr) rx_ready = 1'b0;
    if (!rx_ready && rx_q.size() > 0) begin
      rx_byte  = rx_q.pop_front();
      rx_ready = 1'b1;
    end
  end

  int          rsp_cnt = 0;
  int          rsp_edge = 0;
  logic        m_err = 1'b0;
  logic [7:0]  m_code = 8'd0;
  logic [47:0] m_rd = 48'd0;
  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_cnt  <= rsp_cnt + 1;
      rsp_edge <= cyc + 1;
      m_err    <= rsp_err;
      m_code   <= rsp_code;
      m_rd     <= {rd_weight1, rd_weight2, rd_result};
    end
  end

  int acc_edge = 0;
  int exp_rsp = 0;
  int c0 = 0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] data);
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    step();
    acc_edge  = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input string tag);
    int k = 0;
    while ((tx_log.size() < n || tx_busy) && k < 5000) begin
      step();
      k++;
    end
    chk(tag, tx_log.size(), n);
  endtask

  task automatic wait_rsp(input string tag);
    int k = 0;
    while (rsp_cnt < exp_rsp && k < 5000) begin
      step();
      k++;
    end
    chk(tag, rsp_cnt, exp_rsp);
  endtask

  task automatic wait_clr(input int target, input string tag);
    int k = 0;
    while (clr_cnt < target && k < 5000) begin
      step();
      k++;
    end
    chk(tag, clr_cnt, target);
  endtask

  function automatic logic [39:0] pack5();
    if (tx_log.size() < 5) return 40'd0;
    return {tx_log[0], tx_log[1], tx_log[2], tx_log[3], tx_log[4]};
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tx", {tx_send, tx_byte}, 0);
    chk("rst_rx_clear", rx_clear, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_code}, 0);
    chk("rst_rd", {rd_weight1, rd_weight2, rd_result}, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", cmd_ready, 1);

    // WRITE_WEIGHTS, slave answers OK
    tx_log.delete();
    busy_len = 3;
    issue(2'd0, 32'h0102_0304);
    wait_tx(5, "ww_tx_count");
    chk("ww_latency", first_send_edge - acc_edge, 1);
    chk("ww_tx_bytes", pack5(), 40'h32_01_02_03_04);
    rx_q.push_back(8'h65);
    exp_rsp++;
    wait_rsp("ww_rsp");
    chk("ww_err", m_err, 0);
    chk("ww_code", m_code, 8'h65);

    // WRITE_INPUTS, slave answers ERR
    tx_log.delete();
    issue(2'd1, 32'hFFFF_8000);
    wait_tx(5, "wi_tx_count");
    chk("wi_tx_bytes", pack5(), 40'h33_FF_FF_80_00);
    rx_q.push_back(8'h66);
    exp_rsp++;
    wait_rsp("wi_rsp");
    chk("wi_err", m_err, 1);
    chk("wi_code", m_code, 8'h66);

    // READ with six reply bytes
    tx_log.delete();
    issue(2'd2, 32'hDEAD_BEEF);
    wait_tx(1, "rd_tx_count");
    chk("rd_tx_byte", tx_log[0], 8'h05);
    chk("rd_before", {rd_weight1, rd_weight2, rd_result}, 0);
    rx_q.push_back(8'h00); rx_q.push_back(8'h10); rx_q.push_back(8'hFF);
    rx_q.push_back(8'hF0); rx_q.push_back(8'h01); rx_q.push_back(8'h23);
    exp_rsp++;
    wait_rsp("rd_rsp");
    chk("rd_at_rsp", m_rd, 48'h0010_FFF0_0123);
    chk("rd_err", m_err, 0);
    chk("rd_code", m_code, 8'h23);

    // Slow UART plus a command pulse while busy
    tx_log.delete();
    busy_len = 50;
    issue(2'd0, 32'hA1B2_C3D4);
    repeat (100) step();
    chk("slow_busy", {cmd_ready, busy}, 2'b01);
    cmd_op    = 2'd2;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    wait_tx(5, "slow_tx_count");
    chk("slow_tx_bytes", pack5(), 40'h32_A1_B2_C3_D4);
    rx_q.push_back(8'h65);
    exp_rsp++;
    wait_rsp("slow_rsp");
    repeat (30) step();
    chk("slow_one_rsp", rsp_cnt, exp_rsp);
    chk("slow_no_extra_tx", tx_log.size(), 5);
    chk("send_while_busy", n_viol, 0);
    busy_len = 3;

    // Extra reply byte after completion is dropped in IDLE
    tx_log.delete();
    c0 = clr_cnt;
    issue(2'd1, 32'h1234_5678);
    wait_tx(5, "dup_tx_count");
    rx_q.push_back(8'h65);
    rx_q.push_back(8'h77);
    exp_rsp++;
    wait_rsp("dup_rsp");
    repeat (20) step();
    chk("dup_one_rsp", rsp_cnt, exp_rsp);
    chk("dup_cleared", clr_cnt - c0, 2);
    chk("dup_rx_ready", rx_ready, 0);
    chk("dup_code_kept", {rsp_err, rsp_code}, {1'b0, 8'h65});

    // Reserved opcode: nothing sent, error response
    tx_log.delete();
    issue(2'd3, 32'hCAFE_F00D);
    exp_rsp++;
    wait_rsp("res_rsp");
    chk("res_err_code", {m_err, m_code}, {1'b1, 8'h00});
    chk("res_no_tx", tx_log.size(), 0);
    chk("res_rd_kept", {rd_weight1, rd_weight2, rd_result}, 48'h0010_FFF0_0123);

`ifdef PHM_TIMEOUT_EN
    // READ starved after three bytes
    tx_log.delete();
    issue(2'd2, 32'd0);
    wait_tx(1, "to_tx_count");
    rx_q.push_back(8'h11); rx_q.push_back(8'h22); rx_q.push_back(8'h33);
    exp_rsp++;
    wait_rsp("to_rsp");
    chk("to_err_code", {m_err, m_code}, {1'b1, 8'h00});
    chk("to_delay_ok", (rsp_edge - last_clr_edge >= 95) && (rsp_edge - last_clr_edge <= 110), 1);
    chk("to_rd_kept", {rd_weight1, rd_weight2, rd_result}, 48'h0010_FFF0_0123);
`endif

    // Reset in the middle of a READ
    tx_log.delete();
    issue(2'd2, 32'd0);
    wait_tx(1, "mid_tx_count");
    c0 = clr_cnt;
    rx_q.push_back(8'h44); rx_q.push_back(8'h55);
    wait_clr(c0 + 2, "mid_clears");
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_rd", {rd_weight1, rd_weight2, rd_result}, 0);
    step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("mid_no_rsp", rsp_cnt, exp_rsp);
    chk("mid_idle", {cmd_ready, busy}, 2'b10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
